// File: rtl/fetch_pc_if.sv
// fetch_pc_if
//   Control/fetch bundle between the control decoder (master) and the
//   program-counter unit (slave).
//   Parameters: PC_W (address width), OFF_W (relative branch field width).
//   Master drives : Stall, Branch, Jump, Call, Ret, Target, JumpAddr
//                   (+ Halt when FETCH_HALT_EN is defined)
//   Slave drives  : PC, RasEmpty, RasFull, RasErr
//                   (+ Halted when FETCH_HALT_EN is defined)
//   Optional feature macro: FETCH_HALT_EN.
//   There is no valid/ready pairing here: every control input is a level that
//   is sampled at each rising clock edge, and every output is a registered
//   level that is valid for the whole cycle following that edge.
interface fetch_pc_if #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 3
);
  logic             Stall;
  logic             Branch;
  logic             Jump;
  logic             Call;
  logic             Ret;
  logic [OFF_W-1:0] Target;
  logic [PC_W-1:0]  JumpAddr;
  logic [PC_W-1:0]  PC;
  logic             RasEmpty;
  logic             RasFull;
  logic             RasErr;
`ifdef FETCH_HALT_EN
  logic             Halt;
  logic             Halted;
`endif

  modport master (
    output Stall, Branch, Jump, Call, Ret, Target, JumpAddr,
`ifdef FETCH_HALT_EN
    output Halt,
    input  Halted,
`endif
    input  PC, RasEmpty, RasFull, RasErr
  );

  modport slave (
    input  Stall, Branch, Jump, Call, Ret, Target, JumpAddr,
`ifdef FETCH_HALT_EN
    input  Halt,
    output Halted,
`endif
    output PC, RasEmpty, RasFull, RasErr
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Program-counter / instruction-fetch unit. Each cycle selects the next
//   fetch address from: sequential (+1), relative branch, absolute jump,
//   call (push return address) or return (pop return address).
//   Priority: Init > Stall > Ret > Call > Jump > Branch > sequential.
//   Ports:
//     CLK   - clock, all state updates on the rising edge
//     Init  - synchronous active-high reset
//     bus   - fetch_pc_if.slave (controls in, PC / RAS status out)
//   Optional feature macro: FETCH_HALT_EN adds Halt/Halted; once Halted is
//   set the PC and return stack freeze until Init.
module fetch_pc_unit #(
  parameter int              PC_W      = 8,
  parameter int              OFF_W     = 3,
  parameter int              OFF_SHIFT = 2,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input logic       CLK,
  input logic       Init,
  fetch_pc_if.slave bus
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // Return-address stack: circular buffer. sp points at the next free slot;
  // when full it points at the oldest entry, so a push on full overwrites it.
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [SP_W-1:0]  sp_r,  sp_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [PC_W-1:0]  pc_r,  pc_n;
  logic             err_r, err_n;
  logic             push;
  logic             frozen;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  off;

`ifdef FETCH_HALT_EN
  logic halted_r;

  always_ff @(posedge CLK) begin
    if (Init)
      halted_r <= 1'b0;
    else if (bus.Halt && !bus.Stall)
      halted_r <= 1'b1;
  end

  // The edge that raises Halted still performs its normal update; freezing
  // starts on the following edge.
  assign frozen     = halted_r;
  assign bus.Halted = halted_r;
`else
  assign frozen = 1'b0;
`endif

  // Sign-extend the branch field to PC width, then scale to branch granularity.
  assign off    = PC_W'($signed(bus.Target)) << OFF_SHIFT;
  assign pc_inc = pc_r + PC_ONE;

  always_comb begin
    pc_n  = pc_r;
    sp_n  = sp_r;
    cnt_n = cnt_r;
    err_n = 1'b0;
    push  = 1'b0;
    if (frozen || bus.Stall) begin
      // hold everything; RasErr drops
    end else if (bus.Ret) begin
      if (cnt_r != '0) begin
        pc_n  = ras_mem[sp_r - SP_ONE];
        sp_n  = sp_r - SP_ONE;
        cnt_n = cnt_r - CNT_ONE;
      end else begin
        pc_n  = pc_inc;
        err_n = 1'b1;
      end
    end else if (bus.Call) begin
      push = 1'b1;
      sp_n = sp_r + SP_ONE;
      pc_n = bus.JumpAddr;
      if (cnt_r == CNT_FULL)
        err_n = 1'b1;
      else
        cnt_n = cnt_r + CNT_ONE;
    end else if (bus.Jump) begin
      pc_n = bus.JumpAddr;
    end else if (bus.Branch) begin
      pc_n = pc_r + off;
    end else begin
      pc_n = pc_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (Init) begin
      pc_r  <= RESET_PC;
      sp_r  <= '0;
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      pc_r  <= pc_n;
      sp_r  <= sp_n;
      cnt_r <= cnt_n;
      err_r <= err_n;
    end
  end

  // Stack contents need no reset: the count alone defines what is valid.
  always_ff @(posedge CLK) begin
    if (push && !Init)
      ras_mem[sp_r] <= pc_inc;
  end

  assign bus.PC       = pc_r;
  assign bus.RasEmpty = (cnt_r == '0);
  assign bus.RasFull  = (cnt_r == CNT_FULL);
  assign bus.RasErr   = err_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic CLK = 1'b0;
  logic Init;

  fetch_pc_if #(.PC_W(8), .OFF_W(3)) bus ();

  fetch_pc_unit #(
    .PC_W(8), .OFF_W(3), .OFF_SHIFT(2), .RAS_DEPTH(4), .RESET_PC(8'h00)
  ) dut (
    .CLK  (CLK),
    .Init (Init),
    .bus  (bus)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: PC as a plain number, return stack as a bounded queue
  // (oldest at the front, newest at the back).
  logic [7:0] m_pc;
  logic [7:0] ras_q[$];
  logic       m_err;

  task automatic model_step(input logic i_init, input logic stall, input logic br,
                            input logic jmp, input logic cl, input logic rt,
                            input logic [2:0] tgt, input logic [7:0] ja);
    int off;
    m_err = 1'b0;
    if (i_init) begin
      m_pc = 8'h00;
      ras_q.delete();
    end else if (stall) begin
    end else if (rt) begin
      if (ras_q.size() > 0) m_pc = ras_q.pop_back();
      else begin m_pc = m_pc + 8'd1; m_err = 1'b1; end
    end else if (cl) begin
      if (ras_q.size() == 4) begin
        void'(ras_q.pop_front());
        m_err = 1'b1;
      end
      ras_q.push_back(m_pc + 8'd1);
      m_pc = ja;
    end else if (jmp) begin
      m_pc = ja;
    end else if (br) begin
      off  = int'($signed(tgt)) * 4;
      m_pc = 8'(int'(m_pc) + off);
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  // driver tasks
  task automatic apply(input logic i_init, input logic stall, input logic br,
                       input logic jmp, input logic cl, input logic rt,
                       input logic [2:0] tgt, input logic [7:0] ja);
    Init         = i_init;
    bus.Stall    = stall;
    bus.Branch   = br;
    bus.Jump     = jmp;
    bus.Call     = cl;
    bus.Ret      = rt;
    bus.Target   = tgt;
    bus.JumpAddr = ja;
    @(posedge CLK);
    model_step(i_init, stall, br, jmp, cl, rt, tgt, ja);
    #1;
  endtask

  task automatic do_init();           apply(1, 0, 0, 0, 0, 0, 3'd0, 8'd0); endtask
  task automatic do_idle();           apply(0, 0, 0, 0, 0, 0, 3'd0, 8'd0); endtask
  task automatic do_jump(input logic [7:0] a);   apply(0, 0, 0, 1, 0, 0, 3'd0, a); endtask
  task automatic do_call(input logic [7:0] a);   apply(0, 0, 0, 0, 1, 0, 3'd0, a); endtask
  task automatic do_ret();            apply(0, 0, 0, 0, 0, 1, 3'd0, 8'd0); endtask
  task automatic do_branch(input logic [2:0] t); apply(0, 0, 1, 0, 0, 0, t, 8'd0); endtask

  task automatic test_reset();
    do_init();
    n_vec++;
    if (bus.PC !== 8'h00 || bus.RasEmpty !== 1'b1 || bus.RasFull !== 1'b0 || bus.RasErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: PC=%0d E=%b F=%b Err=%b, want PC=0 E=1 F=0 Err=0",
               bus.PC, bus.RasEmpty, bus.RasFull, bus.RasErr);
    end
    for (int i = 1; i <= 5; i++) begin
      do_idle();
      n_vec++;
      if (bus.PC !== 8'(i) || bus.RasEmpty !== 1'b1 || bus.RasErr !== 1'b0) begin
        n_fail++;
        $display("FAIL seq%0d: PC=%0d E=%b Err=%b, want PC=%0d E=1 Err=0",
                 i, bus.PC, bus.RasEmpty, bus.RasErr, i);
      end
    end
  endtask

  task automatic test_branch();
    do_init();
    do_jump(8'd8);
    do_branch(3'b111);
    n_vec++;
    if (bus.PC !== 8'd4) begin
      n_fail++; $display("FAIL branch_neg: PC=%0d want 4", bus.PC);
    end
    do_branch(3'b011);
    n_vec++;
    if (bus.PC !== 8'd16) begin
      n_fail++; $display("FAIL branch_pos: PC=%0d want 16", bus.PC);
    end
    do_jump(8'hFE);
    do_branch(3'b001);
    n_vec++;
    if (bus.PC !== 8'h02) begin
      n_fail++; $display("FAIL branch_wrap: PC=%h want 02", bus.PC);
    end
    do_jump(8'hFF);
    do_idle();
    n_vec++;
    if (bus.PC !== 8'h00) begin
      n_fail++; $display("FAIL seq_wrap: PC=%h want 00", bus.PC);
    end
  endtask

  task automatic test_call_ret();
    do_init();
    do_jump(8'd5);
    do_call(8'd40);
    n_vec++;
    if (bus.PC !== 8'd40 || bus.RasEmpty !== 1'b0) begin
      n_fail++; $display("FAIL call1: PC=%0d E=%b want PC=40 E=0", bus.PC, bus.RasEmpty);
    end
    do_idle();
    do_idle();
    do_call(8'd60);
    n_vec++;
    if (bus.PC !== 8'd60) begin
      n_fail++; $display("FAIL call2: PC=%0d want 60", bus.PC);
    end
    do_ret();
    n_vec++;
    if (bus.PC !== 8'd43 || bus.RasEmpty !== 1'b0) begin
      n_fail++; $display("FAIL ret1: PC=%0d E=%b want PC=43 E=0", bus.PC, bus.RasEmpty);
    end
    do_ret();
    n_vec++;
    if (bus.PC !== 8'd6 || bus.RasEmpty !== 1'b1 || bus.RasErr !== 1'b0) begin
      n_fail++; $display("FAIL ret2: PC=%0d E=%b Err=%b want PC=6 E=1 Err=0",
                         bus.PC, bus.RasEmpty, bus.RasErr);
    end
  endtask

  task automatic test_ras_overflow();
    logic [7:0] exp_ret[4];
    exp_ret = '{8'd42, 8'd32, 8'd22, 8'd12};
    do_init();
    do_jump(8'd1);
    for (int i = 1; i <= 5; i++) begin
      do_call(8'(i * 10));
      n_vec++;
      if (bus.PC !== 8'(i * 10) || bus.RasFull !== (i >= 4) || bus.RasErr !== (i == 5)) begin
        n_fail++;
        $display("FAIL call_%0d: PC=%0d F=%b Err=%b want PC=%0d F=%b Err=%b",
                 i, bus.PC, bus.RasFull, bus.RasErr, i * 10, (i >= 4), (i == 5));
      end
      if (i < 5) do_idle();
    end
    do_idle();
    n_vec++;
    if (bus.RasErr !== 1'b0 || bus.RasFull !== 1'b1 || bus.PC !== 8'd51) begin
      n_fail++; $display("FAIL err_pulse_push: Err=%b F=%b PC=%0d want Err=0 F=1 PC=51",
                         bus.RasErr, bus.RasFull, bus.PC);
    end
    for (int i = 0; i < 4; i++) begin
      do_ret();
      n_vec++;
      if (bus.PC !== exp_ret[i] || bus.RasErr !== 1'b0 || bus.RasEmpty !== (i == 3)) begin
        n_fail++; $display("FAIL ret_%0d: PC=%0d Err=%b E=%b want PC=%0d Err=0 E=%b",
                           i, bus.PC, bus.RasErr, bus.RasEmpty, exp_ret[i], (i == 3));
      end
    end
    do_ret();
    n_vec++;
    if (bus.PC !== 8'd13 || bus.RasErr !== 1'b1 || bus.RasEmpty !== 1'b1) begin
      n_fail++; $display("FAIL ret_empty: PC=%0d Err=%b E=%b want PC=13 Err=1 E=1",
                         bus.PC, bus.RasErr, bus.RasEmpty);
    end
    do_idle();
    n_vec++;
    if (bus.RasErr !== 1'b0 || bus.PC !== 8'd14) begin
      n_fail++; $display("FAIL err_pulse_pop: Err=%b PC=%0d want Err=0 PC=14", bus.RasErr, bus.PC);
    end
  endtask

  task automatic test_stall();
    do_init();
    do_jump(8'd20);
    do_call(8'd30);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 1, 0, 1, 1, 3'b011, 8'd99);
      n_vec++;
      if (bus.PC !== 8'd30 || bus.RasEmpty !== 1'b0 || bus.RasFull !== 1'b0 || bus.RasErr !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d: PC=%0d E=%b F=%b Err=%b want PC=30 E=0 F=0 Err=0",
                           i, bus.PC, bus.RasEmpty, bus.RasFull, bus.RasErr);
      end
    end
    do_ret();
    n_vec++;
    if (bus.PC !== 8'd21) begin
      n_fail++; $display("FAIL ret_after_stall: PC=%0d want 21", bus.PC);
    end
    do_jump(8'd7);
    apply(1, 0, 0, 0, 1, 0, 3'd0, 8'd40);
    n_vec++;
    if (bus.PC !== 8'd0 || bus.RasEmpty !== 1'b1 || bus.RasErr !== 1'b0) begin
      n_fail++; $display("FAIL init_over_call: PC=%0d E=%b Err=%b want PC=0 E=1 Err=0",
                         bus.PC, bus.RasEmpty, bus.RasErr);
    end
  endtask

  task automatic test_random();
    logic ii, st, br, jp, cl, rt;
    do_init();
    for (int n = 0; n < 400; n++) begin
      ii = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 15);
      rt = ($urandom_range(0, 99) < 25);
      cl = ($urandom_range(0, 99) < 30);
      jp = ($urandom_range(0, 99) < 15);
      br = ($urandom_range(0, 99) < 30);
      apply(ii, st, br, jp, cl, rt, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      n_vec++;
      if (bus.PC !== m_pc || bus.RasEmpty !== (ras_q.size() == 0) ||
          bus.RasFull !== (ras_q.size() == 4) || bus.RasErr !== m_err) begin
        n_fail++;
        $display("FAIL rand_%0d: PC=%0d E=%b F=%b Err=%b want PC=%0d E=%b F=%b Err=%b",
                 n, bus.PC, bus.RasEmpty, bus.RasFull, bus.RasErr,
                 m_pc, (ras_q.size() == 0), (ras_q.size() == 4), m_err);
      end
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    do_init();
    do_jump(8'd9);
    bus.Halt = 1'b1;
    do_idle();
    bus.Halt = 1'b0;
    n_vec++;
    if (bus.Halted !== 1'b1 || bus.PC !== 8'd10) begin
      n_fail++; $display("FAIL halt_set: Halted=%b PC=%0d want 1 10", bus.Halted, bus.PC);
    end
    for (int i = 0; i < 4; i++) begin
      do_jump(8'd77);
      n_vec++;
      if (bus.PC !== 8'd10 || bus.Halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold_%0d: PC=%0d Halted=%b want 10 1", i, bus.PC, bus.Halted);
      end
    end
    do_init();
    n_vec++;
    if (bus.PC !== 8'd0 || bus.Halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_clear: PC=%0d Halted=%b want 0 0", bus.PC, bus.Halted);
    end
  endtask
`endif

  initial begin
    Init         = 1'b1;
    bus.Stall    = 1'b0;
    bus.Branch   = 1'b0;
    bus.Jump     = 1'b0;
    bus.Call     = 1'b0;
    bus.Ret      = 1'b0;
    bus.Target   = '0;
    bus.JumpAddr = '0;
    m_pc         = 8'h00;
    m_err        = 1'b0;
`ifdef FETCH_HALT_EN
    bus.Halt     = 1'b0;
`endif
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_stall();
    test_random();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
